// File: rtl/core_clock_ctrl_if.sv
// Board/core side signal bundle for core_clock_ctrl.
// The controller drives through 'master'; the board/cpu side connects through 'slave'.
interface core_clock_ctrl_if #(
  parameter int unsigned NUM_KEYS = 2
) ();
  logic [NUM_KEYS-1:0] keys_n;
  logic [1:0]          mode;
`ifdef CORE_CLOCK_BURST_EN
  logic [7:0]          burst_len;
`endif
  logic                sys_rst;
  logic                core_ce;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [1:0]          mode_active;
  logic [15:0]         tick_count;

`ifdef CORE_CLOCK_BURST_EN
  modport master (
    input  keys_n, mode, burst_len,
    output sys_rst, core_ce, key_level, key_press, mode_active, tick_count
  );
  modport slave (
    output keys_n, mode, burst_len,
    input  sys_rst, core_ce, key_level, key_press, mode_active, tick_count
  );
`else
  modport master (
    input  keys_n, mode,
    output sys_rst, core_ce, key_level, key_press, mode_active, tick_count
  );
  modport slave (
    output keys_n, mode,
    input  sys_rst, core_ce, key_level, key_press, mode_active, tick_count
  );
`endif
endinterface

// File: rtl/core_clock_ctrl.sv
// Reset stretcher, push-button debouncer and core clock-enable generator for the MCPC core.
// Define CORE_CLOCK_BURST_EN to add burst_len: one step press then yields a burst of enables.
module core_clock_ctrl #(
  parameter int unsigned RST_STRETCH_W = 24,
  parameter int unsigned NUM_KEYS      = 2,
  parameter int unsigned DEBOUNCE_CYC  = 500000,
  parameter int unsigned RESET_KEY     = 0,
  parameter int unsigned STEP_KEY      = 1,
  parameter int unsigned SLOW_DIV      = 21,
  parameter int unsigned FAST_DIV      = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  core_clock_ctrl_if.master ctrl_io
);
  localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYC);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ModeManual = 2'b00,
    ModeSlow   = 2'b01,
    ModeFast   = 2'b10,
    ModeFull   = 2'b11
  } mode_e;

  logic [NUM_KEYS-1:0]      key_s1_q, key_s2_q;
  logic [NUM_KEYS-1:0]      key_lvl_q, key_lvl_d, key_prev_q, key_press;
  logic [DbW-1:0]           db_cnt_q [NUM_KEYS];
  logic [DbW-1:0]           db_cnt_d [NUM_KEYS];
  logic [1:0]               mode_s1_q, mode_s2_q;
  mode_e                    mode_q, mode_d;
  logic [RST_STRETCH_W-1:0] stretch_q, stretch_d;
  logic                     sys_rst_q, sys_rst_d;
  logic                     ce_q, ce_d;
  logic [SLOW_DIV-1:0]      div_q, div_d;
  logic [15:0]              tick_q, tick_d;
  logic                     rst_key, step_key, hold, mode_chg;
`ifdef CORE_CLOCK_BURST_EN
  logic [7:0]               burst_q, burst_d;
`endif

  assign key_press = key_lvl_q & ~key_prev_q;
  assign rst_key   = key_press[RESET_KEY];
  assign step_key  = key_press[STEP_KEY];
  // A reset-key press blocks enables in the same cycle it restarts the stretch.
  assign hold      = sys_rst_q | rst_key;
  assign mode_chg  = (mode_s2_q != mode_q);

  always_comb begin
    key_lvl_d = key_lvl_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      db_cnt_d[k] = '0;
      if (key_s2_q[k] != key_lvl_q[k]) begin
        if (db_cnt_q[k] == DbLast) begin
          key_lvl_d[k] = ~key_lvl_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    stretch_d = stretch_q;
    sys_rst_d = sys_rst_q;
    if (rst_key) begin
      stretch_d = '0;
      sys_rst_d = 1'b1;
    end else if (sys_rst_q) begin
      if (&stretch_q) begin
        stretch_d = '0;
        sys_rst_d = 1'b0;
      end else begin
        stretch_d = stretch_q + RST_STRETCH_W'(1);
      end
    end
  end

  always_comb begin
    mode_d = mode_e'(mode_s2_q);
    div_d  = div_q + SLOW_DIV'(1);
    tick_d = tick_q + (ce_q ? 16'd1 : 16'd0);
    ce_d   = 1'b0;
`ifdef CORE_CLOCK_BURST_EN
    burst_d = burst_q;
`endif
    if (hold) begin
      div_d  = '0;
      tick_d = '0;
`ifdef CORE_CLOCK_BURST_EN
      burst_d = '0;
`endif
    end else if (mode_chg) begin
      // Switch cycle: clean divider restart, no enable, so no runt or doubled pulse.
      div_d = '0;
`ifdef CORE_CLOCK_BURST_EN
      burst_d = '0;
`endif
    end else begin
      unique case (mode_q)
        ModeManual: begin
`ifdef CORE_CLOCK_BURST_EN
          if (burst_q != 8'd0) begin
            ce_d    = 1'b1;
            burst_d = burst_q - 8'd1;
          end else if (step_key) begin
            ce_d    = 1'b1;
            burst_d = (ctrl_io.burst_len == 8'd0) ? 8'd0 : ctrl_io.burst_len - 8'd1;
          end
`else
          ce_d = step_key;
`endif
        end
        ModeSlow: ce_d = &div_q;
        ModeFast: ce_d = &div_q[FAST_DIV-1:0];
        ModeFull: ce_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      key_lvl_q  <= '0;
      key_prev_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= '0;
      mode_s1_q  <= '0;
      mode_s2_q  <= '0;
      mode_q     <= ModeManual;
      stretch_q  <= '0;
      sys_rst_q  <= 1'b1;
      ce_q       <= 1'b0;
      div_q      <= '0;
      tick_q     <= '0;
`ifdef CORE_CLOCK_BURST_EN
      burst_q    <= '0;
`endif
    end else begin
      key_s1_q   <= ~ctrl_io.keys_n;
      key_s2_q   <= key_s1_q;
      key_lvl_q  <= key_lvl_d;
      key_prev_q <= key_lvl_q;
      for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
      mode_s1_q  <= ctrl_io.mode;
      mode_s2_q  <= mode_s1_q;
      mode_q     <= mode_d;
      stretch_q  <= stretch_d;
      sys_rst_q  <= sys_rst_d;
      ce_q       <= ce_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
`ifdef CORE_CLOCK_BURST_EN
      burst_q    <= burst_d;
`endif
    end
  end

  assign ctrl_io.sys_rst     = sys_rst_q;
  assign ctrl_io.core_ce     = ce_q;
  assign ctrl_io.key_level   = key_lvl_q;
  assign ctrl_io.key_press   = key_press;
  assign ctrl_io.mode_active = mode_q;
  assign ctrl_io.tick_count  = tick_q;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Bench for core_clock_ctrl: directed scenarios plus random key/mode traffic, every cycle
// compared against a cycle-count reference model.
module tb_core_clock_ctrl;
  localparam int StretchLen = 16;  // 2^RST_STRETCH_W
  localparam int DebN       = 4;
  localparam int SlowP      = 16;  // 2^SLOW_DIV
  localparam int FastP      = 2;   // 2^FAST_DIV

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_clock_ctrl_if #(.NUM_KEYS(2)) ifc ();

  core_clock_ctrl #(
    .RST_STRETCH_W(4),
    .NUM_KEYS     (2),
    .DEBOUNCE_CYC (4),
    .RESET_KEY    (0),
    .STEP_KEY     (1),
    .SLOW_DIV     (4),
    .FAST_DIV     (1)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ctrl_io(ifc)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [1:0] m_ks0, m_ks1, m_ms0, m_ms1;
  logic [1:0] m_lvl, m_lvl_old, m_act;
  int         m_run [2];
  logic       m_srst, m_ce;
  int         m_age, m_phase, m_tick, m_burst;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int burst_pulses();
`ifdef CORE_CLOCK_BURST_EN
    return (ifc.burst_len == 8'd0) ? 1 : int'(ifc.burst_len);
`else
    return 1;
`endif
  endfunction

  task automatic model_reset();
    m_ks0 = '0; m_ks1 = '0; m_ms0 = '0; m_ms1 = '0;
    m_lvl = '0; m_lvl_old = '0; m_act = '0;
    m_run[0] = 0; m_run[1] = 0;
    m_srst = 1'b1; m_ce = 1'b0;
    m_age = 0; m_phase = 0; m_tick = 0; m_burst = 0;
  endtask

  task automatic model_update();
    logic [1:0] kp, lvl_before;
    logic       rk, sk, hold, chg, nce;
    kp   = m_lvl & ~m_lvl_old;
    rk   = kp[0];
    sk   = kp[1];
    hold = m_srst | rk;
    chg  = (m_ms1 != m_act);
    nce  = 1'b0;
    if (hold || chg) begin
      m_burst = 0;
    end else begin
      case (m_act)
        2'b00: begin
          if (m_burst > 0) begin
            nce = 1'b1;
            m_burst--;
          end else if (sk) begin
            nce = 1'b1;
            m_burst = burst_pulses() - 1;
          end
        end
        2'b01:   nce = ((m_phase % SlowP) == SlowP - 1);
        2'b10:   nce = ((m_phase % FastP) == FastP - 1);
        default: nce = 1'b1;
      endcase
    end
    m_tick  = hold ? 0 : (m_tick + int'(m_ce)) % 65536;
    m_phase = (hold || chg) ? 0 : m_phase + 1;
    m_act   = m_ms1;
    // stretch: high for StretchLen cycles after each restart
    if (rk) begin
      m_srst = 1'b1;
      m_age  = 0;
    end else if (m_srst) begin
      m_age++;
      if (m_age == StretchLen) begin
        m_srst = 1'b0;
        m_age  = 0;
      end
    end
    lvl_before = m_lvl;
    for (int k = 0; k < 2; k++) begin
      if (m_ks1[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DebN) begin
          m_lvl[k] = ~m_lvl[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_lvl_old = lvl_before;
    m_ks1 = m_ks0;
    m_ks0 = ~ifc.keys_n;
    m_ms1 = m_ms0;
    m_ms0 = ifc.mode;
    m_ce  = nce;
  endtask

  task automatic compare_all();
    check_eq("sys_rst",     32'(ifc.sys_rst),     32'(m_srst));
    check_eq("core_ce",     32'(ifc.core_ce),     32'(m_ce));
    check_eq("key_level",   32'(ifc.key_level),   32'(m_lvl));
    check_eq("key_press",   32'(ifc.key_press),   32'(m_lvl & ~m_lvl_old));
    check_eq("mode_active", 32'(ifc.mode_active), 32'(m_act));
    check_eq("tick_count",  32'(ifc.tick_count),  32'(m_tick));
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic press(input int key, input int low_cyc, input int high_cyc);
    ifc.keys_n[key] = 1'b0;
    run(low_cyc);
    ifc.keys_n[key] = 1'b1;
    run(high_cyc);
  endtask

  initial begin
    logic [1:0] mv;
    int         r;
    ifc.keys_n = 2'b11;
    ifc.mode   = 2'b00;
`ifdef CORE_CLOCK_BURST_EN
    ifc.burst_len = 8'd1;
`endif
    model_reset();
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(24);

    // bounce rejected, then a real step press
    press(1, 3, 10);
    press(1, 10, 12);

    ifc.mode = 2'b01;
    run(64);
    ifc.mode = 2'b11;
    run(20);
    press(0, 8, 30);
    ifc.mode = 2'b10;
    run(20);

`ifdef CORE_CLOCK_BURST_EN
    ifc.mode = 2'b00;
    run(10);
    ifc.burst_len = 8'd5;
    press(1, 6, 20);
    ifc.burst_len = 8'd20;
    press(1, 6, 4);
    press(1, 6, 40);
    ifc.burst_len = 8'd0;
    press(1, 6, 15);
`endif

    for (int s = 0; s < 80; s++) begin
`ifdef CORE_CLOCK_BURST_EN
      ifc.burst_len = 8'($urandom_range(0, 6));
`endif
      r = int'($urandom_range(0, 10));
      if (r < 3) begin
        mv = 2'($urandom_range(0, 3));
        ifc.mode = mv;
        run(int'($urandom_range(5, 40)));
      end else if (r < 7) begin
        press(1, int'($urandom_range(1, 9)), int'($urandom_range(3, 15)));
      end else if (r == 7) begin
        press(0, int'($urandom_range(5, 7)), int'($urandom_range(5, 25)));
      end else if (r == 8) begin
        for (int i = 0; i < 8; i++) begin
          ifc.keys_n = 2'($urandom_range(0, 3));
          run_cycle();
        end
        ifc.keys_n = 2'b11;
        run(12);
      end else if (r == 9) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(int'($urandom_range(5, 30)));
      end else begin
        run(int'($urandom_range(1, 30)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
